instr_fetch_unit: RTL and testbench

// - Producer side of the decoder interface: fetches 32-bit instructions from instruction

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/ifu_pc_next.sv | 24 ++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants: address width, default reset PC, major opcodes and the
// instruction-fetch state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_L    = 7'b0000011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC select for the fetch unit: sequential pc+4 or word-aligned redirect
// target, plus detection of a redirect target with non-zero low bits.
module ifu_pc_next
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_misalign
);

  always_comb begin
    o_pc_next  = i_pc + XLEN'(4);
    o_misalign = 1'b0;
    if (i_redirect) begin
      o_pc_next  = {i_redirect_pc[XLEN-1:2], 2'b00};
      o_misalign = (i_redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory request at a time and
// presents each fetched word to the decoder until it is acknowledged.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ack,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_d;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic [31:0]     r_count;
  logic            r_misalign;

  logic            w_ack;
  logic            w_capture;
  logic [XLEN-1:0] w_pc_next;
  logic            w_misalign;

  ifu_pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .i_pc         (r_pc),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_pc_next    (w_pc_next),
    .o_misalign   (w_misalign)
  );

  // Ack and redirect only mean something while an instruction is presented.
  assign w_ack     = (r_state == StHold) && instr_ack;
  assign w_capture = (r_state == StWait) && imem_rsp_valid;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: w_state_d = StReq;
      StReq:  if (imem_req_ready) w_state_d = StWait;
      StWait: if (imem_rsp_valid) w_state_d = StHold;
      StHold: if (instr_ack) w_state_d = StReq;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_instr    <= imem_rsp_data;
        r_instr_pc <= r_pc;
      end
      if (w_ack) begin
        r_pc    <= w_pc_next;
        r_count <= r_count + 32'd1;
        if (w_misalign) r_misalign <= 1'b1;
      end
    end
  end

  // Address comes straight from the PC, which only moves on ack, so it is
  // stable for as long as a request waits for ready.
  always_comb begin
    imem_req_valid = (r_state == StReq);
    imem_req_addr  = r_pc;
    instr_valid    = (r_state == StHold);
    instr          = r_instr;
    instr_pc       = r_instr_pc;
    misalign_err   = r_misalign;
    fetch_count    = r_count;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table of fetches plus hand-written
// sequences for early responses, ignored acks and reset during a fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        req_valid, req_valid2;
  logic [31:0] req_addr, req_addr2;
  logic        instr_valid, instr_valid2;
  logic [31:0] instr, instr2;
  logic [31:0] instr_pc, instr_pc2;
  logic        misalign_err, misalign_err2;
  logic [31:0] fetch_count, fetch_count2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ack     (instr_ack),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  // Second instance starting at the top of the address space, driven in lockstep.
  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_top (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(req_valid2),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (req_addr2),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid2),
    .instr         (instr2),
    .instr_pc      (instr_pc2),
    .instr_ack     (instr_ack),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err2),
    .fetch_count   (fetch_count2)
  );

  typedef struct {
    logic [31:0] data;
    int          stall;
    logic        redir_no_ack;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] next;
    logic        mis;
    logic [6:0]  op;
    logic [31:0] pc2;
    logic [31:0] next2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with both DUTs in REQ; leaves them in HOLD with the word presented.
  task automatic fetch(input logic [31:0] data, input logic [31:0] pc, input logic [31:0] pc2,
                       input int stall);
    chk("req_valid", 32'(req_valid), 32'd1);
    chk("req_addr", req_addr, pc);
    chk("req_addr_top", req_addr2, pc2);
    imem_req_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", 32'(req_valid), 32'd1);
      chk("stall_addr", req_addr, pc);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_no_req", 32'(req_valid), 32'd0);
    chk("wait_no_instr", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, pc);
    chk("instr_pc_top", instr_pc2, pc2);
  endtask

  task automatic ack(input logic redir, input logic [31:0] rpc);
    instr_ack   = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    step();
    instr_ack   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0033, 0, 1'b0, 1'b0, 32'h0, 32'h00, 32'h04, 1'b0, 7'b0110011,
                32'hFFFF_FFFC, 32'h0000_0000};
    vecs[1] = '{32'h0000_0013, 0, 1'b0, 1'b0, 32'h0, 32'h04, 32'h08, 1'b0, 7'b0010011,
                32'h0, 32'h4};
    vecs[2] = '{32'h0000_006F, 3, 1'b1, 1'b0, 32'h40, 32'h08, 32'h0C, 1'b0, 7'b1101111,
                32'h4, 32'h8};
    vecs[3] = '{32'h00A0_0093, 0, 1'b0, 1'b1, 32'h40, 32'h0C, 32'h40, 1'b0, 7'b0010011,
                32'h8, 32'h40};
    vecs[4] = '{32'h0000_0063, 0, 1'b0, 1'b1, 32'h43, 32'h40, 32'h40, 1'b1, 7'b1100011,
                32'h40, 32'h40};
    vecs[5] = '{32'h0000_0013, 0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h44, 1'b1, 7'b0010011,
                32'h40, 32'h44};

    // Reset with a stray response on the bus.
    #2 rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    step();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_req_addr_top", req_addr2, 32'hFFFF_FFFC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);

    rst_n = 1'b1;
    chk("idle_no_req", 32'(req_valid), 32'd0);
    step();
    chk("stale_rsp_in_req", 32'(instr_valid), 32'd0);
    chk("stale_rsp_instr", instr, 32'h0);
    imem_rsp_valid = 1'b0;

    foreach (vecs[i]) begin
      fetch(vecs[i].data, vecs[i].pc, vecs[i].pc2, vecs[i].stall);
      chk("opcode", 32'(instr[6:0]), 32'(vecs[i].op));
      if (vecs[i].redir_no_ack) begin
        redirect    = 1'b1;
        redirect_pc = vecs[i].rpc;
        step();
        redirect    = 1'b0;
        chk("redir_no_ack_hold", 32'(instr_valid), 32'd1);
        chk("redir_no_ack_count", fetch_count, 32'(i));
      end
      ack(vecs[i].redir, vecs[i].rpc);
      chk("next_valid", 32'(req_valid), 32'd1);
      chk("next_addr", req_addr, vecs[i].next);
      chk("next_addr_top", req_addr2, vecs[i].next2);
      chk("count", fetch_count, 32'(i + 1));
      chk("misalign", 32'(misalign_err), 32'(vecs[i].mis));
    end
    chk("count_top", fetch_count2, 32'd6);
    chk("misalign_top", 32'(misalign_err2), 32'd1);

    // Response in the handshake cycle is dropped; ack while waiting is ignored.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ack      = 1'b1;
    redirect       = 1'b1;
    redirect_pc    = 32'h100;
    chk("early_no_instr", 32'(instr_valid), 32'd0);
    chk("early_instr_held", instr, 32'h0000_0013);
    step();
    instr_ack = 1'b0;
    redirect  = 1'b0;
    chk("early_still_wait", 32'(instr_valid), 32'd0);
    chk("early_no_req", 32'(req_valid), 32'd0);
    chk("wait_ack_count", fetch_count, 32'd6);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0033;
    step();
    imem_rsp_valid = 1'b0;
    chk("late_instr", instr, 32'h0000_0033);
    chk("late_instr_pc", instr_pc, 32'h44);
    ack(1'b0, 32'h0);
    chk("late_next_addr", req_addr, 32'h48);
    chk("late_count", fetch_count, 32'd7);

    // Reset while waiting for a response; stale response arrives afterwards.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_addr", req_addr, 32'h0);
    chk("mid_rst_addr_top", req_addr2, 32'hFFFF_FFFC);
    chk("mid_rst_count", fetch_count, 32'h0);
    chk("mid_rst_misalign", 32'(misalign_err), 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_instr_pc", instr_pc, 32'h0);
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    step();
    imem_rsp_valid = 1'b0;
    chk("restart_no_instr", 32'(instr_valid), 32'd0);
    chk("restart_instr", instr, 32'h0);
    fetch(32'h0000_0013, 32'h0, 32'hFFFF_FFFC, 0);
    ack(1'b0, 32'h0);
    chk("restart_next_addr", req_addr, 32'h4);
    chk("restart_count", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
